// File: rtl/scoreboard_register_file.sv
// Register file with per-register pending-write scoreboard; 2 comb read ports, 1 sync write port.
// Latency: reads 0 cycles, writes/issues visible next cycle (same cycle with REGFILE_BYPASS_EN).
// Backpressure: stall_o asserted while a source operand awaits writeback; optional macro REGFILE_BYPASS_EN.
module scoreboard_register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2,
    parameter int ZERO_REG   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] rs_i,
    input  logic [ADDR_WIDTH-1:0] rt_i,
    output logic [DATA_WIDTH-1:0] read_rs_o,
    output logic [DATA_WIDTH-1:0] read_rt_o,
    input  logic                  reg_write_i,
    input  logic [ADDR_WIDTH-1:0] rd_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic                  issue_vld_i,
    input  logic [ADDR_WIDTH-1:0] issue_rd_i,
    output logic                  rs_busy_o,
    output logic                  rt_busy_o,
    output logic                  stall_o,
    output logic [ADDR_WIDTH:0]   pending_count_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      pend_q;
    logic [DEPTH-1:0]      pend_d;

    logic wr_ok;
    logic iss_ok;
    logic rs_zero;
    logic rt_zero;
    logic rs_byp;
    logic rt_byp;

    assign wr_ok   = reg_write_i && !((ZERO_REG != 0) && (rd_i == '0));
    assign iss_ok  = issue_vld_i && !((ZERO_REG != 0) && (issue_rd_i == '0));
    assign rs_zero = (ZERO_REG != 0) && (rs_i == '0);
    assign rt_zero = (ZERO_REG != 0) && (rt_i == '0);

`ifdef REGFILE_BYPASS_EN
    assign rs_byp = reg_write_i && !rst_i && (rd_i == rs_i);
    assign rt_byp = reg_write_i && !rst_i && (rd_i == rt_i);
`else
    assign rs_byp = 1'b0;
    assign rt_byp = 1'b0;
`endif

    // Issue is applied after the write so a same-cycle newer producer keeps the register pending.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_ok) begin
            regs_d[rd_i] = write_data_i;
            pend_d[rd_i] = 1'b0;
        end
        if (iss_ok) begin
            pend_d[issue_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        read_rs_o = regs_q[rs_i];
        read_rt_o = regs_q[rt_i];
        rs_busy_o = pend_q[rs_i];
        rt_busy_o = pend_q[rt_i];
        if (rs_byp) begin
            read_rs_o = write_data_i;
            rs_busy_o = 1'b0;
        end
        if (rt_byp) begin
            read_rt_o = write_data_i;
            rt_busy_o = 1'b0;
        end
        if (rs_zero) begin
            read_rs_o = '0;
            rs_busy_o = 1'b0;
        end
        if (rt_zero) begin
            read_rt_o = '0;
            rt_busy_o = 1'b0;
        end
    end

    assign stall_o = rs_busy_o | rt_busy_o;

    always_comb begin
        pending_count_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_count_o = pending_count_o + {{ADDR_WIDTH{1'b0}}, pend_q[i]};
        end
    end

endmodule
